// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and limits for the multiply-accumulate stage
//
// Purpose : FSM state encoding, product width and legal parameter limits
//           used by mult_accum_stage.
// Ports   : none (package).

package mult_pkg;

  // Width of the unsigned product delivered by the upstream 4x4 multiplier.
  localparam int P_W = 8;

  // Legal parameter ranges for mult_accum_stage.
  localparam int LEN_MIN   = 1;
  localparam int LEN_MAX   = 16;
  localparam int ACC_W_MIN = 8;
  localparam int ACC_W_MAX = 16;

  // IDLE: no product collected; ACC: partial sum in progress; HOLD: result presented.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/mult_accum_stage.sv
// rtl/mult_accum_stage.sv - sums LEN unsigned products and presents the result
//
// Purpose : Accumulates LEN products from the upstream array multiplier,
//           then holds the result until the downstream consumer takes it.
//           Build option MULT_ACCUM_SAT_EN: when defined the accumulator
//           saturates at all-ones instead of wrapping; ovf is the same in
//           both builds.
// Ports   : clk        - clock, rising edge
//           rst        - synchronous active-high reset
//           clr        - synchronous flush of the partial sum / held result
//           p          - unsigned product (P_W bits)
//           in_valid   - p is valid
//           in_ready   - stage accepts p (high in IDLE and ACC)
//           sum        - result (ACC_W bits), zero outside HOLD
//           out_valid  - sum is valid (HOLD)
//           out_ready  - downstream accepts sum
//           ovf        - an addition carried out of ACC_W for this result

module mult_accum_stage
  import mult_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [P_W-1:0]   p,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam int ADD_W = ACC_W + 1;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ADD_W-1:0] add_full;
  logic             carry;
  logic [ACC_W-1:0] acc_next_sum;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign sum       = (state_q == HOLD) ? acc_q : '0;
  assign ovf       = ovf_q;

  // One extra bit captures the carry out of the accumulator width.
  assign add_full = ADD_W'(acc_q) + ADD_W'(p);
  assign carry    = add_full[ACC_W];
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef MULT_ACCUM_SAT_EN
  assign acc_next_sum = carry ? '1 : add_full[ACC_W-1:0];
`else
  assign acc_next_sum = add_full[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    // clr wins over both accept and out_ready.
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // p is never wider than ACC_W, so the first load cannot overflow.
            acc_d   = ACC_W'(p);
            cnt_d   = CNT_W'(1);
            state_d = (LEN == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = acc_next_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
            if (cnt_inc == CNT_W'(LEN)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : mult_accum_stage

// File: doc/mult_accum_stage.md
MULT_ACCUM_STAGE -- requirements
Module: mult_accum_stage

Interface
REQ-001 SHALL have parameter LEN, default 4: number of products summed per result; legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 12: accumulator and result width; legal range 8..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port clr, input, 1: synchronous flush of the partial sum.
REQ-006 SHALL have port p, input, 8: unsigned product from the upstream 4x4 array multiplier.
REQ-007 SHALL have port in_valid, input, 1: p is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: stage accepts p this cycle.
REQ-009 SHALL have port sum, output, ACC_W: accumulated result.
REQ-010 SHALL have port out_valid, output, 1: sum is valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts sum.
REQ-012 SHALL have port ovf, output, 1: sum overflowed ACC_W during this result.

Function
REQ-013 SHALL use an FSM with states IDLE (cnt=0), ACC (0<cnt<LEN) and HOLD (result presented).
REQ-014 SHALL define accept as in_valid && in_ready, and SHALL drive in_ready=1 in IDLE and ACC and 0 in HOLD.
REQ-015 SHALL, on accept in IDLE, load acc=p and cnt=1, then go to ACC, or to HOLD if LEN==1.
REQ-016 SHALL, on accept in ACC, set acc=acc+p and cnt=cnt+1, and go to HOLD when the new cnt equals LEN.
REQ-017 SHALL drive out_valid=1 and sum=acc only in HOLD, starting the cycle after the LEN-th accept (latency 1); sum and ovf SHALL be held stable while out_ready=0.
REQ-018 SHALL, when out_ready=1 in HOLD, clear acc, cnt and ovf and go to IDLE; no input is accepted in that same cycle.
REQ-019 SHALL zero-extend p to ACC_W before adding, and SHALL wrap acc modulo 2^ACC_W by default.
REQ-020 SHALL set ovf when any addition carries out of ACC_W, holding it until the result is consumed.
REQ-021 SHALL, on clr=1, go to IDLE and zero acc, cnt and ovf next cycle in any state (HOLD result discarded); clr SHALL take priority over accept and over out_ready, and in_ready SHALL still follow REQ-014.
REQ-022 SHALL hold state in IDLE/ACC when in_valid=0, with no change to acc or cnt.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, go to IDLE with acc=0, cnt=0, ovf=0, out_valid=0 and sum=0; rst SHALL override clr and all handshakes.
REQ-024 SHALL make in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, when macro MULT_ACCUM_SAT_EN is defined, saturate acc at 2^ACC_W-1 on overflow instead of wrapping; ovf SHALL behave identically in both builds.
REQ-026 SHALL, when MULT_ACCUM_SAT_EN is undefined, wrap per REQ-019 and contain no saturation logic.

Structure
REQ-027 SHALL take the FSM state enum (IDLE, ACC, HOLD), the product width constant (8) and the LEN/ACC_W legal limits from shared package mult_pkg.
REQ-028 SHALL size cnt as $clog2(LEN+1) bits.
REQ-029 SHALL be a single module with no sub-modules; a test wrapper MAY pair it with the upstream array multiplier.

Verification
REQ-030 SHALL verify: LEN=4, p=225 accepted on 4 consecutive cycles, out_ready=1 -> sum=900, ovf=0, out_valid high exactly 1 cycle, the cycle after the 4th accept.
REQ-031 SHALL verify: LEN=2, p=10 then 20, out_ready=0 for 5 cycles -> sum=30 held, in_ready=0 throughout; releasing out_ready -> IDLE, in_ready=1 next cycle.
REQ-032 SHALL verify: ACC_W=8, LEN=2, p=200 then 100 -> without MULT_ACCUM_SAT_EN sum=44, ovf=1; with it sum=255, ovf=1.
REQ-033 SHALL verify: LEN=4, after 2 accepts (p=5,7) assert rst 1 cycle -> acc=0, out_valid=0; next 4 products p=1 -> sum=4.
REQ-034 SHALL verify: in HOLD with sum=30, assert clr and out_ready together -> result discarded, IDLE, sum=0, out_valid=0 next cycle.
REQ-035 SHALL verify: LEN=1, p=255 with in_valid held high and out_ready=1 -> a result every 2 cycles, sum=255 each time.
